// File: rtl/seg_capture.sv
// seg_capture: samples a multiplexed active-low 7-segment bus,
// debounces each digit and returns complete hex frames over valid/ready.
module seg_capture #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_pattern,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  acc_q, acc_d;
  logic                  fdone_q, fdone_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;

  logic [NUM_DIGITS-1:0] sel_in;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  legal;
  logic                  same;
  logic [3:0]            nib;
  logic                  code_ok;

  assign sel_in = ~an_in;
  assign sel_q  = ~an_q;
  assign legal  = (sel_in != '0) &&
                  ((sel_in & (sel_in - 1'b1)) == '0);
  assign same   = (an_in == an_q) && (seg_in == seg_q);

  // Accept fires only on the edge the run length reaches the limit.
  always_comb begin
    cnt_d = '0;
    acc_d = 1'b0;
    if (legal) begin
      if (same)
        cnt_d = (cnt_q == CMAX) ? CMAX : cnt_q + CW'(1);
      else
        cnt_d = CW'(1);
      acc_d = (cnt_d == CMAX) && !(same && cnt_q == CMAX);
    end
  end

  always_comb begin
    nib     = 4'h0;
    code_ok = 1'b1;
    unique case (seg_q)
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h10:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h03:   nib = 4'hB;
      7'h46:   nib = 4'hC;
      7'h21:   nib = 4'hD;
      7'h06:   nib = 4'hE;
      7'h0E:   nib = 4'hF;
      default: code_ok = 1'b0;
    endcase
  end

  // The sample regs still hold the accepted pair on the accept edge.
  always_comb begin
    shadow_d = shadow_q;
    seen_d   = fdone_q ? '0 : seen_q;
    err_d    = acc_q && !code_ok;
    if (acc_q && code_ok) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_q[i]) begin
          shadow_d[4*i +: 4] = nib;
          seen_d[i]          = 1'b1;
        end
      end
    end
    fdone_d = acc_q && code_ok && (&seen_d);
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (fdone_q) begin
      if (!valid_q || out_ready) begin
        data_d  = shadow_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q     <= '1;
      seg_q    <= 7'h7F;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      fdone_q  <= 1'b0;
      shadow_q <= '0;
      seen_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      an_q     <= an_in;
      seg_q    <= seg_in;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      fdone_q  <= fdone_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_out    = data_q;
  assign out_valid   = valid_q;
  assign err_pattern = err_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed scenarios plus random bus traffic,
// checked every cycle against a history-based reference model.
module tb_seg_capture;

  localparam int ND = 8;
  localparam int SC = 4;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [7:0]  an_in = 8'hFF;
  logic        out_ready = 1'b1;
  logic [31:0] data_out;
  logic        out_valid;
  logic        err_pattern;
  logic        overrun;

  seg_capture #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .an_in(an_in),
    .data_out(data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_pattern(err_pattern),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_tests = 0;
  int n_fail  = 0;

  pair_t       hist[$];
  logic [31:0] m_shadow, m_data, m_frame;
  logic [7:0]  m_seen;
  bit          m_valid, m_err, m_ovr;
  bit          pend_acc, pend_frame;
  pair_t       pend_pair;

  int          vcount, errs, ovrs;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] an);
    return $countones(~an) == 1;
  endfunction

  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 16; k++)
      if (seg_tab[k] == s) return k;
    return -1;
  endfunction

  // Number of consecutive identical legal samples ending now.
  function automatic int run_len();
    int    n;
    pair_t last;
    n = 0;
    last = hist[hist.size()-1];
    if (!is_legal(last.an)) return 0;
    for (int j = hist.size() - 1; j >= 0; j--) begin
      if (hist[j] !== last) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_edge();
    bit nxt_frame;
    int d, nb;
    if (!rst_n) begin
      m_shadow = '0; m_data = '0; m_frame = '0; m_seen = '0;
      m_valid = 0; m_err = 0; m_ovr = 0;
      pend_acc = 0; pend_frame = 0;
      hist.delete();
      hist.push_back({8'hFF, 7'h7F});
      return;
    end
    m_err = 0;
    m_ovr = 0;
    nxt_frame = 0;
    if (pend_frame) begin
      if (!m_valid || out_ready) begin
        m_data  = m_frame;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      m_seen = '0;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (pend_acc) begin
      d = 0;
      for (int k = 0; k < ND; k++)
        if (!pend_pair.an[k]) d = k;
      nb = decode(pend_pair.seg);
      if (nb < 0) begin
        m_err = 1;
      end else begin
        m_shadow[4*d +: 4] = nb[3:0];
        m_seen[d] = 1'b1;
        if (&m_seen) begin
          nxt_frame = 1;
          m_frame = m_shadow;
        end
      end
    end
    hist.push_back({an_in, seg_in});
    if (hist.size() > 16) void'(hist.pop_front());
    pend_acc   = (run_len() == SC);
    pend_pair  = hist[hist.size()-1];
    pend_frame = nxt_frame;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("data_out", data_out, m_data);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("err_pattern", {31'd0, err_pattern}, {31'd0, m_err});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (out_valid) begin
      vcount++;
      last_data = data_out;
    end
    if (err_pattern) errs++;
    if (overrun) ovrs++;
  endtask

  task automatic clr_stats();
    vcount = 0; errs = 0; ovrs = 0; last_data = '0;
  endtask

  task automatic show(input int d, input logic [6:0] code, input int n);
    an_in  = ~(8'(1) << d);
    seg_in = code;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    an_in  = 8'hFF;
    seg_in = 7'h7F;
    repeat (n) tick();
  endtask

  initial begin
    int r, hold, d;
    logic [6:0] code;
    logic [7:0] an;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_data", data_out, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_err", {31'd0, err_pattern}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;

    clr_stats();
    for (int i = 0; i < ND; i++) show(i, seg_tab[i+1], 4);
    idle(4);
    chk("scan_vcnt", vcount, 1);
    chk("scan_data", last_data, 32'h87654321);

    clr_stats();
    for (int i = 0; i < ND; i++) show(i, seg_tab[8-i], (i == 3) ? 3 : 4);
    idle(6);
    chk("short_novalid", vcount, 0);
    show(3, seg_tab[5], 4);
    idle(4);
    chk("rescan_vcnt", vcount, 1);
    chk("rescan_data", last_data, 32'h12345678);

    clr_stats();
    for (int i = 0; i < ND; i++)
      show(i, (i == 2) ? 7'h7F : seg_tab[i+1], 4);
    idle(6);
    chk("blank_err", errs, 1);
    chk("blank_noframe", vcount, 0);
    show(2, 7'h24, 4);
    idle(4);
    chk("fix_vcnt", vcount, 1);
    chk("fix_data", last_data, 32'h87654221);

    clr_stats();
    out_ready = 1'b0;
    for (int i = 0; i < ND; i++) show(i, seg_tab[i+1], 4);
    idle(4);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < ND; i++) show(i, seg_tab[0], 4);
    idle(4);
    chk("ovr_count", ovrs, 1);
    chk("ovr_data", data_out, 32'h87654321);
    chk("ovr_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 5; i++) show(i, seg_tab[9], 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clr_stats();
    for (int i = 0; i < ND; i++) show(i, seg_tab[15], 4);
    idle(4);
    chk("post_rst_vcnt", vcount, 1);
    chk("post_rst_data", last_data, 32'hFFFFFFFF);

    repeat (300) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else if (r < 30) begin
        for (int i = 0; i < ND; i++) begin
          an_in  = ~(8'(1) << i);
          seg_in = seg_tab[$urandom_range(0, 15)];
          hold   = $urandom_range(SC, SC + 1);
          repeat (hold) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
          end
        end
      end else begin
        d = $urandom_range(0, ND - 1);
        an = ~(8'(1) << d);
        if (r < 36) an = (r[0]) ? 8'hFF : (an & ~(8'(1) << ((d + 1) % ND)));
        if ($urandom_range(0, 9) == 0) code = 7'($urandom_range(0, 127));
        else code = seg_tab[$urandom_range(0, 15)];
        an_in  = an;
        seg_in = code;
        hold   = $urandom_range(1, 6);
        repeat (hold) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    end
    out_ready = 1'b1;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
